// File: rtl/dual_fetch_queue_if.sv
// Fetch/decode handshake bundle for dual_fetch_queue.
// master = fetch/decode/EX side, slave = the queue.
interface dual_fetch_queue_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic [1:0]    push_cnt;
    logic [31:0]   push_pc;
    logic [31:0]   push_instr0;
    logic [31:0]   push_instr1;
    logic          push_ready;
    logic [1:0]    pop_cnt;
    logic          d0_valid;
    logic [31:0]   d0_pc;
    logic [31:0]   d0_instr;
    logic          d1_valid;
    logic [31:0]   d1_pc;
    logic [31:0]   d1_instr;
    logic [CW-1:0] count;
    logic          ovf_err;

    modport master (
        output flush, push_cnt, push_pc, push_instr0, push_instr1, pop_cnt,
        input  push_ready, d0_valid, d0_pc, d0_instr, d1_valid, d1_pc, d1_instr, count, ovf_err
    );

    modport slave (
        input  flush, push_cnt, push_pc, push_instr0, push_instr1, pop_cnt,
        output push_ready, d0_valid, d0_pc, d0_instr, d1_valid, d1_pc, d1_instr, count, ovf_err
    );
endinterface

// File: rtl/dual_fetch_queue.sv
// Dual-in/dual-out instruction buffer between fetch and dual-issue decode.
// Define FETCHQ_BYPASS_EN to forward pushes straight to decode when the queue is empty.
module dual_fetch_queue #(
    parameter int unsigned DEPTH = 8,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    dual_fetch_queue_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic          push_ready;
    logic          byp;
    logic [1:0]    req_push;
    logic [1:0]    pop_req;
    logic [1:0]    pop_eff;
    logic [1:0]    n_push;
    logic [1:0]    skip;
    logic [1:0]    stored;
    logic [CW-1:0] avail;
    logic [1:0]    we;
    logic [AW-1:0] waddr [2];
    logic [31:0]   wpc   [2];
    logic [31:0]   winstr[2];
    logic [AW-1:0] rd1_ptr;

    always_comb begin
        push_ready = (cnt_q <= CW'(DEPTH - 2));
        req_push   = (bus.push_cnt == 2'd3) ? 2'd2 : bus.push_cnt;
        pop_req    = (bus.pop_cnt == 2'd3) ? 2'd2 : bus.pop_cnt;

        byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        byp = (cnt_q == '0) && !bus.flush && (req_push != 2'd0);
`endif

        // In bypass the only entries decode can see are the incoming words.
        avail   = byp ? CW'(req_push) : cnt_q;
        pop_eff = (CW'(pop_req) > avail) ? avail[1:0] : pop_req;
        n_push  = (!bus.flush && push_ready) ? req_push : 2'd0;
        skip    = byp ? pop_eff : 2'd0;
        stored  = n_push - skip;

        we[0]     = (n_push != 2'd0) && (skip == 2'd0);
        we[1]     = (n_push == 2'd2) && (skip != 2'd2);
        waddr[0]  = wr_ptr_q;
        waddr[1]  = wr_ptr_q + ((skip == 2'd1) ? AW'(0) : AW'(1));
        wpc[0]    = bus.push_pc;
        wpc[1]    = bus.push_pc + 32'd4;
        winstr[0] = bus.push_instr0;
        winstr[1] = bus.push_instr1;

        rd_ptr_d = rd_ptr_q + (byp ? AW'(0) : AW'(pop_eff));
        wr_ptr_d = wr_ptr_q + AW'(stored);
        cnt_d    = cnt_q + CW'(n_push) - CW'(pop_eff);
        ovf_d    = ovf_q;

        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else if (((req_push != 2'd0) && !push_ready) || (bus.push_cnt == 2'd3) ||
                     (CW'(bus.pop_cnt) > avail)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is never read while invalid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (we[0]) begin
                mem_pc[waddr[0]]    <= wpc[0];
                mem_instr[waddr[0]] <= winstr[0];
            end
            if (we[1]) begin
                mem_pc[waddr[1]]    <= wpc[1];
                mem_instr[waddr[1]] <= winstr[1];
            end
        end
    end

    always_comb begin
        rd1_ptr        = rd_ptr_q + AW'(1);
        bus.push_ready = push_ready;
        bus.count      = cnt_q;
        bus.ovf_err    = ovf_q;

        bus.d0_valid = (cnt_q >= CW'(1));
        bus.d1_valid = (cnt_q >= CW'(2));
        bus.d0_pc    = mem_pc[rd_ptr_q];
        bus.d0_instr = mem_instr[rd_ptr_q];
        bus.d1_pc    = mem_pc[rd1_ptr];
        bus.d1_instr = mem_instr[rd1_ptr];

        if (byp) begin
            bus.d0_valid = 1'b1;
            bus.d1_valid = (req_push == 2'd2);
            bus.d0_pc    = bus.push_pc;
            bus.d0_instr = bus.push_instr0;
            bus.d1_pc    = bus.push_pc + 32'd4;
            bus.d1_instr = bus.push_instr1;
        end

        if (!bus.d0_valid) begin
            bus.d0_pc    = '0;
            bus.d0_instr = NOP;
        end
        if (!bus.d1_valid) begin
            bus.d1_pc    = '0;
            bus.d1_instr = NOP;
        end
    end
endmodule

// File: tb/tb_dual_fetch_queue.sv
// Directed self-checking bench for dual_fetch_queue (DEPTH=8).
module tb_dual_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    dual_fetch_queue_if #(.DEPTH(8)) bus ();

    dual_fetch_queue #(.DEPTH(8), .NOP(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'hA500_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic idle_inputs();
        bus.flush       = 1'b0;
        bus.push_cnt    = 2'd0;
        bus.push_pc     = 32'h0;
        bus.push_instr0 = 32'h0;
        bus.push_instr1 = 32'h0;
        bus.pop_cnt     = 2'd0;
    endtask

    // One clock with the given request; inputs return to idle and outputs settle before checks.
    task automatic cyc(input logic [1:0] pn, input logic [31:0] pc, input logic [1:0] qn,
                       input logic fl);
        bus.flush       = fl;
        bus.push_cnt    = pn;
        bus.push_pc     = pc;
        bus.push_instr0 = ins(pc);
        bus.push_instr1 = ins(pc + 32'd4);
        bus.pop_cnt     = qn;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        idle_inputs();
        do_reset(3);

        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_d0_valid", 32'(bus.d0_valid), 32'd0);
        check("rst_d1_valid", 32'(bus.d1_valid), 32'd0);
        check("rst_d0_instr", bus.d0_instr, NOP);
        check("rst_d1_instr", bus.d1_instr, NOP);
        check("rst_d0_pc", bus.d0_pc, 32'h0);
        check("rst_push_ready", 32'(bus.push_ready), 32'd1);
        check("rst_ovf", 32'(bus.ovf_err), 32'd0);

        // Two-word push, no pop
        bus.push_cnt    = 2'd2;
        bus.push_pc     = 32'h0;
        bus.push_instr0 = 32'h0050_0093;
        bus.push_instr1 = 32'h00a0_0113;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("p2_count", 32'(bus.count), 32'd2);
        check("p2_d0_pc", bus.d0_pc, 32'h0);
        check("p2_d1_pc", bus.d1_pc, 32'h4);
        check("p2_d0_instr", bus.d0_instr, 32'h0050_0093);
        check("p2_d1_instr", bus.d1_instr, 32'h00a0_0113);
        check("p2_d0_valid", 32'(bus.d0_valid), 32'd1);
        check("p2_d1_valid", 32'(bus.d1_valid), 32'd1);

        // Fill: 2 -> 4 -> 6 (still ready) -> 8 (stalled)
        cyc(2'd2, 32'h8, 2'd0, 1'b0);
        check("fill4_count", 32'(bus.count), 32'd4);
        cyc(2'd2, 32'h10, 2'd0, 1'b0);
        check("fill6_count", 32'(bus.count), 32'd6);
        check("fill6_ready", 32'(bus.push_ready), 32'd1);
        cyc(2'd2, 32'h18, 2'd0, 1'b0);
        check("fill8_count", 32'(bus.count), 32'd8);
        check("fill8_ready", 32'(bus.push_ready), 32'd0);
        check("fill8_ovf", 32'(bus.ovf_err), 32'd0);
        cyc(2'd2, 32'h20, 2'd0, 1'b0);
        check("full_push_count", 32'(bus.count), 32'd8);
        check("full_push_ovf", 32'(bus.ovf_err), 32'd1);
        check("full_d0_pc", bus.d0_pc, 32'h0);

        // Reset mid-operation discards everything
        do_reset(1);
        check("rst2_count", 32'(bus.count), 32'd0);
        check("rst2_d0_valid", 32'(bus.d0_valid), 32'd0);
        check("rst2_ovf", 32'(bus.ovf_err), 32'd0);

        // Offset pointers to 2 so the 7-entry fill wraps
        cyc(2'd2, 32'h100, 2'd0, 1'b0);
        cyc(2'd0, 32'h0, 2'd2, 1'b0);
        check("off_count", 32'(bus.count), 32'd0);
        cyc(2'd2, 32'h0, 2'd0, 1'b0);
        cyc(2'd2, 32'h8, 2'd0, 1'b0);
        cyc(2'd2, 32'h10, 2'd0, 1'b0);
        cyc(2'd1, 32'h18, 2'd0, 1'b0);
        check("fill7_count", 32'(bus.count), 32'd7);
        check("fill7_ready", 32'(bus.push_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wrap%0d_d0_pc", i), bus.d0_pc, 32'(i * 8));
            check($sformatf("wrap%0d_d1_pc", i), bus.d1_pc, 32'(i * 8 + 4));
            check($sformatf("wrap%0d_d1_instr", i), bus.d1_instr, ins(32'(i * 8 + 4)));
            cyc(2'd0, 32'h0, 2'd2, 1'b0);
        end
        check("wrap_last_count", 32'(bus.count), 32'd1);
        check("wrap_last_d0_valid", 32'(bus.d0_valid), 32'd1);
        check("wrap_last_d1_valid", 32'(bus.d1_valid), 32'd0);
        check("wrap_last_d0_pc", bus.d0_pc, 32'h18);
        check("wrap_last_d1_instr", bus.d1_instr, NOP);
        cyc(2'd0, 32'h0, 2'd1, 1'b0);
        check("empty_count", 32'(bus.count), 32'd0);
        check("empty_d0_valid", 32'(bus.d0_valid), 32'd0);
        check("empty_d0_instr", bus.d0_instr, NOP);
        check("empty_ovf", 32'(bus.ovf_err), 32'd0);

        // Over-pop on empty queue
        cyc(2'd0, 32'h0, 2'd2, 1'b0);
        check("overpop_count", 32'(bus.count), 32'd0);
        check("overpop_ovf", 32'(bus.ovf_err), 32'd1);

        // Flush beats same-cycle push and pop
        do_reset(1);
        cyc(2'd2, 32'h40, 2'd0, 1'b0);
        cyc(2'd2, 32'h48, 2'd0, 1'b0);
        cyc(2'd1, 32'h50, 2'd0, 1'b0);
        check("preflush_count", 32'(bus.count), 32'd5);
        cyc(2'd2, 32'h60, 2'd2, 1'b1);
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_d0_valid", 32'(bus.d0_valid), 32'd0);
        check("flush_d1_valid", 32'(bus.d1_valid), 32'd0);
        check("flush_ovf", 32'(bus.ovf_err), 32'd0);

        // Restart after flush, then push and pop in one cycle
        cyc(2'd2, 32'h200, 2'd0, 1'b0);
        check("post_flush_d0_pc", bus.d0_pc, 32'h200);
        cyc(2'd2, 32'h208, 2'd1, 1'b0);
        check("pushpop_count", 32'(bus.count), 32'd3);
        check("pushpop_d0_pc", bus.d0_pc, 32'h204);
        check("pushpop_d1_instr", bus.d1_instr, ins(32'h208));

        // push_cnt=3 behaves as 2 and flags the error
        cyc(2'd3, 32'h210, 2'd0, 1'b0);
        check("pc3_count", 32'(bus.count), 32'd5);
        check("pc3_ovf", 32'(bus.ovf_err), 32'd1);
        check("pc3_d0_pc", bus.d0_pc, 32'h204);

`ifdef FETCHQ_BYPASS_EN
        do_reset(1);
        bus.push_cnt    = 2'd2;
        bus.push_pc     = 32'h300;
        bus.push_instr0 = ins(32'h300);
        bus.push_instr1 = ins(32'h304);
        bus.pop_cnt     = 2'd1;
        #1;
        check("byp_d0_instr", bus.d0_instr, ins(32'h300));
        check("byp_d1_instr", bus.d1_instr, ins(32'h304));
        check("byp_d0_valid", 32'(bus.d0_valid), 32'd1);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("byp_next_count", 32'(bus.count), 32'd1);
        check("byp_next_d0_pc", bus.d0_pc, 32'h304);
        check("byp_next_d0_instr", bus.d0_instr, ins(32'h304));
        check("byp_ovf", 32'(bus.ovf_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
